// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C memory-mapped subordinate.
package i2c_pkg;

    localparam int DEV_AW = 7;
    localparam int MEM_AW = 7;

    localparam logic [DEV_AW-1:0] I2C_DEV_ADDR  = 7'h66;
    localparam int                I2C_MEM_DEPTH = 128;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_DEV_ADDR = 4'd1;
    localparam state_t ST_DEV_ACK  = 4'd2;
    localparam state_t ST_MEM_ADDR = 4'd3;
    localparam state_t ST_MEM_ACK  = 4'd4;
    localparam state_t ST_WR_DATA  = 4'd5;
    localparam state_t ST_WR_ACK   = 4'd6;
    localparam state_t ST_RD_DATA  = 4'd7;
    localparam state_t ST_RD_ACK   = 4'd8;
    localparam state_t ST_WAIT     = 4'd9;

endpackage

// File: rtl/i2c_if.sv
// Synchronized view of one bus line: settled level plus single-cycle edge strobes.
interface i2c_if;

    logic level;
    logic rise;
    logic fall;

    modport master (output level, rise, fall);
    modport slave  (input  level, rise, fall);

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line with rise/fall detection.
module i2c_sync_edge (
    input  logic   clk,
    input  wire    pin,
    i2c_if.master  line
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Data-only flops: left unreset so a reset never manufactures a false edge.
    always_ff @(posedge clk) begin
        sync_p0 <= pin;
        sync_p1 <= sync_p0;
        sync_p2 <= sync_p1;
    end

    assign line.level = sync_p1;
    assign line.rise  = sync_p1 & ~sync_p2;
    assign line.fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/i2c_top.sv
// I2C subordinate exposing a 128x8 memory; SDA open-drain on GPIO_0[0], SCL on GPIO_0[1].
module i2c_top
    import i2c_pkg::*;
#(
    parameter logic [DEV_AW-1:0] DEV_ADDR  = I2C_DEV_ADDR,
    parameter int                MEM_DEPTH = I2C_MEM_DEPTH
) (
    input  logic [3:0]  KEY,
    input  logic        clk,
    inout  wire  [35:0] GPIO_0,
    output logic [9:0]  LEDR
);

    localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(MEM_DEPTH - 1);

    logic              rst;
    logic              unused_key;
    logic [7:0]        mem [MEM_DEPTH];
    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [MEM_AW-1:0] ptr;
    logic              rw;
    logic              matched;
    logic              limit;
    logic              ack_ph;
    logic              sda_low;
    logic [7:0]        last_byte;
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;
    logic              start;
    logic              stop;
    logic              mem_we;

    assign rst        = ~KEY[0];
    assign unused_key = ^KEY[3:1];

    i2c_if scl_if ();
    i2c_if sda_if ();

    i2c_sync_edge u_scl_sync (.clk(clk), .pin(GPIO_0[1]), .line(scl_if));
    i2c_sync_edge u_sda_sync (.clk(clk), .pin(GPIO_0[0]), .line(sda_if));

    assign GPIO_0[0]    = sda_low ? 1'b0 : 1'bz;
    assign GPIO_0[1]    = 1'bz;
    assign GPIO_0[35:2] = {34{1'bz}};

    assign start   = sda_if.fall & scl_if.level;
    assign stop    = sda_if.rise & scl_if.level;
    assign rx_byte = {shreg[6:0], sda_if.level};
    assign rd_byte = mem[ptr];
    assign mem_we  = ~rst & ~start & ~stop & (state == ST_WR_DATA) & scl_if.rise
                   & (bit_cnt == 3'd7) & ~limit;

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            ptr       <= '0;
            rw        <= 1'b0;
            matched   <= 1'b0;
            limit     <= 1'b0;
            ack_ph    <= 1'b0;
            sda_low   <= 1'b0;
            last_byte <= 8'h00;
        end else if (stop) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            matched <= 1'b0;
            limit   <= 1'b0;
            ack_ph  <= 1'b0;
            sda_low <= 1'b0;
        end else if (start) begin
            state   <= ST_DEV_ADDR;
            bit_cnt <= 3'd0;
            ack_ph  <= 1'b0;
            sda_low <= 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR, ST_MEM_ADDR, ST_WR_DATA: begin
                    if (scl_if.rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_ph <= 1'b0;
                            case (state)
                                ST_DEV_ADDR: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        matched <= 1'b1;
                                        rw      <= rx_byte[0];
                                        state   <= ST_DEV_ACK;
                                    end else begin
                                        state <= ST_WAIT;
                                    end
                                end
                                ST_MEM_ADDR: begin
                                    ptr   <= rx_byte[7:1];
                                    rw    <= rx_byte[0];
                                    state <= ST_MEM_ACK;
                                end
                                default: begin
                                    // Once the last cell is filled, further bytes are refused.
                                    if (limit) begin
                                        state <= ST_WAIT;
                                    end else begin
                                        last_byte <= rx_byte;
                                        state     <= ST_WR_ACK;
                                        if (ptr == LAST_ADDR) limit <= 1'b1;
                                        else                  ptr   <= ptr + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                // First SCL fall asserts ACK, second one ends the 9th clock.
                ST_DEV_ACK, ST_MEM_ACK, ST_WR_ACK: begin
                    if (scl_if.fall) begin
                        if (!ack_ph) begin
                            ack_ph  <= 1'b1;
                            sda_low <= 1'b1;
                        end else begin
                            ack_ph  <= 1'b0;
                            bit_cnt <= 3'd0;
                            sda_low <= 1'b0;
                            if (state == ST_DEV_ACK && rw) begin
                                state   <= ST_RD_DATA;
                                shreg   <= rd_byte;
                                sda_low <= ~rd_byte[7];
                            end else if (state == ST_DEV_ACK) begin
                                state <= ST_MEM_ADDR;
                            end else if (state == ST_MEM_ACK && rw) begin
                                state <= ST_WAIT;
                            end else begin
                                state <= ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_if.fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low <= 1'b0;
                            bit_cnt <= 3'd0;
                            ack_ph  <= 1'b0;
                            if (ptr == LAST_ADDR) begin
                                limit <= 1'b1;
                                state <= ST_WAIT;
                            end else begin
                                state <= ST_RD_ACK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            sda_low <= ~shreg[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_if.rise) begin
                        if (sda_if.level) begin
                            state <= ST_WAIT;
                        end else begin
                            ack_ph <= 1'b1;
                            ptr    <= ptr + 1'b1;
                        end
                    end else if (scl_if.fall && ack_ph) begin
                        ack_ph  <= 1'b0;
                        bit_cnt <= 3'd0;
                        state   <= ST_RD_DATA;
                        shreg   <= rd_byte;
                        sda_low <= ~rd_byte[7];
                    end
                end
                default: begin
                    sda_low <= 1'b0;
                end
            endcase
        end
    end

    assign LEDR = {limit, matched, last_byte};

endmodule

// File: tb/tb_i2c_top.sv
// Directed bench for i2c_top: a bit-banged I2C master with hand-computed expectations.
module tb_i2c_top;

    localparam int Q = 5;

    logic        clk = 1'b0;
    logic [3:0]  key;
    wire  [35:0] gpio;
    wire  [9:0]  ledr;
    logic        m_sda;
    logic        m_scl;
    logic        mon_en;
    logic        drive_seen;
    logic        sda_prev;
    int          n_vec;
    int          n_bad;

    always #5 clk = ~clk;

    pullup (gpio[0]);
    assign gpio[0] = m_sda ? 1'bz : 1'b0;
    assign gpio[1] = m_scl;

    i2c_top dut (.KEY(key), .clk(clk), .GPIO_0(gpio), .LEDR(ledr));

    i2c_if bus_mon ();
    assign bus_mon.level = gpio[0];
    assign bus_mon.fall  = sda_prev & ~gpio[0];
    assign bus_mon.rise  = ~sda_prev & gpio[0];

    always @(negedge clk) begin
        sda_prev <= gpio[0];
        if (mon_en && m_sda && (!bus_mon.level || bus_mon.fall)) drive_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(Q);
        s = gpio[0];  tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~m_ack, s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;
        n_vec = 0; n_bad = 0;
        mon_en = 1'b0; drive_seen = 1'b0;
        m_sda = 1'b1; m_scl = 1'b1;
        key = 4'hE;
        tick(6);
        key = 4'hF;
        tick(3);
        check_eq("reset_ledr", 32'(ledr), 32'h000);
        check_eq("reset_sda",  32'(gpio[0]), 32'h1);

        // Write burst running into the last memory cell
        bus_start();
        send_byte(8'hCC, a); check_eq("wr_dev_ack", 32'(a), 32'h0);
        send_byte(8'hFC, a); check_eq("wr_mem_ack", 32'(a), 32'h0);
        send_byte(8'h01, a); check_eq("wr_d0_ack", 32'(a), 32'h0);
        check_eq("wr_d0_ledr", 32'(ledr), 32'h101);
        send_byte(8'h02, a); check_eq("wr_d1_ack", 32'(a), 32'h0);
        check_eq("wr_d1_ledr", 32'(ledr), 32'h302);
        send_byte(8'h06, a); check_eq("wr_d2_nack", 32'(a), 32'h1);
        check_eq("wr_limit_ledr", 32'(ledr), 32'h302);
        bus_stop();
        check_eq("wr_stop_ledr", 32'(ledr), 32'h002);

        // Read back 0x7E/0x7F through a repeated START
        bus_start();
        send_byte(8'hCC, a); check_eq("rd1_dev_ack", 32'(a), 32'h0);
        send_byte(8'hFD, a); check_eq("rd1_mem_ack", 32'(a), 32'h0);
        bus_start();
        send_byte(8'hCD, a); check_eq("rd1_devr_ack", 32'(a), 32'h0);
        recv_byte(1'b1, d);  check_eq("rd1_byte0", 32'(d), 32'h01);
        recv_byte(1'b0, d);  check_eq("rd1_byte1", 32'(d), 32'h02);
        bus_stop();

        // Read starting at the last cell: the byte after it reads as released bus
        bus_start();
        send_byte(8'hCC, a); check_eq("rd2_dev_ack", 32'(a), 32'h0);
        send_byte(8'hFF, a); check_eq("rd2_mem_ack", 32'(a), 32'h0);
        bus_start();
        send_byte(8'hCD, a); check_eq("rd2_devr_ack", 32'(a), 32'h0);
        recv_byte(1'b1, d);  check_eq("rd2_byte0", 32'(d), 32'h02);
        recv_byte(1'b0, d);  check_eq("rd2_byte1", 32'(d), 32'hFF);
        bus_stop();
        check_eq("rd2_stop_ledr", 32'(ledr), 32'h002);

        // Foreign address: never acknowledged, SDA never pulled
        mon_en = 1'b1;
        bus_start();
        send_byte(8'h4D, a); check_eq("bad_addr_nack", 32'(a), 32'h1);
        check_eq("bad_addr_ledr8", 32'(ledr[8]), 32'h0);
        send_byte(8'hFF, a); check_eq("bad_addr_next", 32'(a), 32'h1);
        bus_stop();
        mon_en = 1'b0;
        check_eq("bad_addr_no_drive", 32'(drive_seen), 32'h0);

        // Reset pulse in the middle of a write data byte (0x3C)
        bus_start();
        send_byte(8'hCC, a); check_eq("rst_dev_ack", 32'(a), 32'h0);
        send_byte(8'h10, a); check_eq("rst_mem_ack", 32'(a), 32'h0);
        send_byte(8'hA5, a); check_eq("rst_d0_ack", 32'(a), 32'h0);
        check_eq("rst_d0_ledr", 32'(ledr), 32'h1A5);
        clk_bit(1'b0, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
        key = 4'hE; tick(1); key = 4'hF; tick(1);
        check_eq("rst_mid_ledr", 32'(ledr), 32'h000);
        check_eq("rst_mid_sda",  32'(gpio[0]), 32'h1);
        clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
        clk_bit(1'b0, s); clk_bit(1'b0, s);
        clk_bit(1'b1, a); check_eq("rst_after_nack", 32'(a), 32'h1);
        check_eq("rst_after_ledr", 32'(ledr), 32'h000);
        bus_stop();

        // Memory survives the reset
        bus_start();
        send_byte(8'hCC, a);
        send_byte(8'h11, a); check_eq("keep_mem_ack", 32'(a), 32'h0);
        bus_start();
        send_byte(8'hCD, a); check_eq("keep_devr_ack", 32'(a), 32'h0);
        recv_byte(1'b0, d);  check_eq("keep_mem08", 32'(d), 32'hA5);
        bus_stop();
        bus_start();
        send_byte(8'hCC, a);
        send_byte(8'hFD, a);
        bus_start();
        send_byte(8'hCD, a);
        recv_byte(1'b1, d);  check_eq("keep_mem7e", 32'(d), 32'h01);
        recv_byte(1'b0, d);  check_eq("keep_mem7f", 32'(d), 32'h02);
        bus_stop();
        check_eq("final_ledr", 32'(ledr), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_top.md
I2C_TOP -- requirements
Module: i2c_top

Interface
REQ-001 Parameters: DEV_ADDR = 7'h66 (7-bit subordinate address, binary 1100110); MEM_DEPTH = 128 (bytes, addresses 0x00-0x7F).
REQ-002 Port order SHALL be KEY, clk, GPIO_0, LEDR.
REQ-003 clk  input  1  system clock, single clock domain; one clock; at least 8 clk periods per SCL period.
REQ-004 KEY  input  4  pushbuttons, active-low; KEY[0] low SHALL generate internal rst; KEY[3:1] unused.
REQ-005 rst (internal) SHALL be synchronous and active-high, equal to ~KEY[0].
REQ-006 GPIO_0  inout  36  GPIO_0[0] = SDA (open-drain), GPIO_0[1] = SCL (input only, never driven); all other bits SHALL be high-Z.
REQ-007 LEDR  output  10  LEDR[7:0] = last byte written to memory; LEDR[8] = address matched (transaction active); LEDR[9] = last-address limit hit.

Function
REQ-008 SDA and SCL SHALL each pass through a 2-flop synchronizer before use; edges detected on synchronized values.
REQ-009 START/repeated START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be recognized in every state and override it.
REQ-010 SDA SHALL be driven only low or Z; SDA changes only after a detected SCL falling edge, within 3 clk; data sampled on SCL rising edge; MSB first.
REQ-011 States: IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
REQ-012 IDLE -> DEV_ADDR on START; 8 bits shifted (7-bit address + R/W).
REQ-013 Address == DEV_ADDR: ACK (SDA low for 9th SCL clock); R/W=0 -> MEM_ADDR, R/W=1 -> RD_DATA at current pointer. Mismatch: no ACK, -> WAIT.
REQ-014 MEM_ADDR byte: bits[7:1] load the 7-bit memory pointer, bit[0] = direction; ACK always; bit0=0 -> WR_DATA, bit0=1 -> WAIT for repeated START.
REQ-015 WR_DATA: each byte stored at pointer, LEDR[7:0] updated, ACK, pointer increments.
REQ-016 Boundary: after byte stored at 0x7F, limit flag set; next write byte SHALL NOT be stored, SHALL be NACKed (SDA released), -> WAIT, LEDR[9]=1.
REQ-017 RD_DATA: slave drives mem[pointer] bits, releases SDA during 9th clock; master ACK -> pointer increments, next byte; master NACK -> WAIT.
REQ-018 Boundary: after transmitting byte 0x7F, slave SHALL go to WAIT regardless of master ACK and release SDA (bus reads 0xFF).
REQ-019 WAIT: SDA released; exits only on START (-> DEV_ADDR) or STOP (-> IDLE).
REQ-020 STOP clears limit flag and LEDR[8]; pointer retained.

Reset
REQ-021 On rst: state IDLE, SDA released, pointer 0x00, bit counter 0, limit flag 0, LEDR all 0; memory contents SHALL NOT be cleared.
REQ-022 rst mid-transaction SHALL abort immediately; next activity requires a fresh START.

Structure
REQ-023 Shared package i2c_pkg: state enum, DEV_ADDR, MEM_DEPTH, address width constants.
REQ-024 One sub-module i2c_sync_edge (2-flop synchronizer + rise/fall detect), instantiated for SDA and SCL; memory SHALL be an inferred 128x8 array in i2c_top.

Verification
REQ-025 Write 0x66+W, mem byte 0xFC (addr 0x7E, W), data 0x01, 0x02, 0x06 -> ACK, ACK, ACK, ACK, NACK; mem[0x7E]=0x01, mem[0x7F]=0x02, LEDR[7:0]=0x02, LEDR[9]=1.
REQ-026 Then 0x66+W, mem byte 0xFD (0x7E, R), repeated START, 0x66+R, master ACK, NACK -> bytes read 0x01, 0x02.
REQ-027 0x66+W, mem byte 0xFF, repeated START, 0x66+R, master ACK -> first byte mem[0x7F], second byte 0xFF (SDA released), STOP -> IDLE.
REQ-028 START, address 0x26+R -> 9th clock SDA high (NACK), no SDA drive until STOP.
REQ-029 KEY[0]=0 for 1 clk during WR_DATA -> state IDLE, SDA Z, LEDR=0, prior memory preserved.
